fifo_uart_tx: RTL and testbench

Downstream drain stage for the team's 8-entry synchronous byte FIFO. It pulls bytes through the FIFO's rd/empty handshake, allowing for the FIFO's one-cycle registered read latency, and serialises each byte as an 8N1 UART frame on a single tx line. It sits between the FIFO read port and the board-level serial pin.

---
 rtl/fifo_uart_pkg.sv | 20 ++
 rtl/baud_tick_gen.sv | 34 +++
 rtl/fifo_uart_tx.sv | 105 ++++++++++
 tb/tb_fifo_uart_tx.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
//   tx_state_t        : drain/serialiser FSM states
//   UART_DATA_BITS    : data bits per frame
//   UART_STOP_LEVEL   : line level for stop bit and idle
//   UART_START_LEVEL  : line level for start bit
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam int unsigned UART_DATA_BITS   = 8;
  localparam logic        UART_STOP_LEVEL  = 1'b1;
  localparam logic        UART_START_LEVEL = 1'b0;

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer for the UART transmitter.
//   clk   : system clock
//   rst   : asynchronous active-low reset
//   clr   : synchronous clear of the count
//   tick  : high while the count sits on its last value (CLKS_PER_BIT-1)
module baud_tick_gen
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr || (count == LAST)) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// Drains bytes from a synchronous FIFO (one-cycle registered read latency)
// and serialises each as an 8N1 UART frame, LSB first.
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   tx_en      : drain enable; gates new FIFO reads only
//   fifo_empty : FIFO empty flag
//   fifo_data  : FIFO read data, valid the cycle after fifo_rd
//   fifo_rd    : one-cycle read strobe, only ever raised in IDLE
//   tx         : registered serial line, idles high
//   busy       : high whenever the FSM is not IDLE
//   frame_done : pulse on the last cycle of the stop bit
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BW = $clog2(UART_DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

  tx_state_t         state;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0]     bit_idx;
  logic              tick;
  logic              baud_clr;

  // Holding the timer clear through IDLE and FETCH makes START begin on a
  // fresh count, so every bit lasts exactly CLKS_PER_BIT cycles.
  assign baud_clr = (state == IDLE) || (state == FETCH);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (baud_clr),
    .tick(tick)
  );

  // rst is folded in so no read strobe reaches the FIFO while reset is held
  // (the FSM already sits in IDLE during reset).
  assign fifo_rd    = rst && (state == IDLE) && tx_en && !fifo_empty;
  assign busy       = (state != IDLE);
  assign frame_done = (state == STOP) && tick;

  // tx is loaded with the level of the state being entered, so the pin
  // changes on the same edge as the state and comes straight from a flop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      tx      <= UART_STOP_LEVEL;
      shift   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_rd) state <= FETCH;
        end
        FETCH: begin
          shift <= fifo_data;
          tx    <= UART_START_LEVEL;
          state <= START;
        end
        START: begin
          if (tick) begin
            tx      <= shift[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            shift <= shift >> 1;
            if (bit_idx == LAST_BIT) begin
              tx    <= UART_STOP_LEVEL;
              state <= STOP;
            end else begin
              tx      <= shift[1];
              bit_idx <= bit_idx + BW'(1);
            end
          end
        end
        STOP: begin
          if (tick) state <= IDLE;
        end
        default: begin
          tx    <= UART_STOP_LEVEL;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: a queue-based FIFO model with
// registered read data, and a reference timeline of expected line levels
// built from each byte's 8N1 frame whenever a read is expected.
module tb_fifo_uart_tx;

  localparam int unsigned CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int fd_cnt = 0;

  logic [7:0] mem[$];
  logic       force_empty = 1'b0;
  // {tx, busy, frame_done} expected per cycle; empty means idle
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W      (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_en     (tx_en),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd   (fifo_rd),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic upd_empty();
    fifo_empty = force_empty || (mem.size() == 0);
  endtask

  task automatic push_byte(input logic [7:0] b);
    mem.push_back(b);
    upd_empty();
  endtask

  // Expected waveform for the 41 cycles following a read strobe:
  // one FETCH cycle at idle level, then start, 8 data bits LSB first, stop.
  task automatic push_frame(input logic [7:0] b);
    logic lvl;
    exp_q.push_back(3'b110);
    for (int k = 0; k < 10; k++) begin
      if (k == 0)      lvl = 1'b0;
      else if (k == 9) lvl = 1'b1;
      else             lvl = b[k-1];
      for (int j = 0; j < int'(CPB); j++)
        exp_q.push_back({lvl, 1'b1, (k == 9) && (j == int'(CPB) - 1)});
    end
  endtask

  task automatic step();
    logic [2:0] e;
    logic       erd;
    logic       rd_now;
    @(negedge clk);
    e   = (exp_q.size() > 0) ? exp_q[0] : 3'b100;
    erd = rst && (exp_q.size() == 0) && tx_en && !fifo_empty;
    chk("tx", tx, e[2]);
    chk("busy", busy, e[1]);
    chk("frame_done", frame_done, e[0]);
    chk("fifo_rd", fifo_rd, erd);
    chk("rd_while_empty", fifo_rd & fifo_empty, 1'b0);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    if (frame_done) fd_cnt++;
    rd_now = fifo_rd;
    if (rd_now) rd_cnt++;
    if (rd_now && erd) push_frame(mem[0]);
    @(posedge clk);
    #1;
    if (rd_now && mem.size() > 0) fifo_data = mem.pop_front();
    upd_empty();
  endtask

  task automatic wait_rd(input string tag);
    int s;
    s = rd_cnt;
    for (int i = 0; i < 100 && rd_cnt == s; i++) step();
    chk(tag, rd_cnt, s + 1);
  endtask

  initial begin
    rst       = 1'b0;
    tx_en     = 1'b1;
    fifo_data = 8'h00;
    push_byte(8'hA5);

    // reset held with a non-empty FIFO
    repeat (3) step();
    rst = 1'b1;
    step();
    chk("first_rd_after_reset", rd_cnt, 1);
    repeat (45) step();
    chk("a5_frames", fd_cnt, 1);
    chk("a5_reads", rd_cnt, 1);

    // back-to-back 0x00 then 0xFF
    push_byte(8'h00);
    push_byte(8'hFF);
    repeat (90) step();
    chk("b2b_reads", rd_cnt, 3);
    chk("b2b_frames", fd_cnt, 3);

    // drain disabled with data waiting
    tx_en = 1'b0;
    for (int i = 0; i < 3; i++) push_byte(8'($urandom));
    repeat (50) step();
    chk("en_low_no_rd", rd_cnt, 3);

    // enable drops mid-DATA
    tx_en = 1'b1;
    wait_rd("en_rise_rd");
    repeat (15) step();
    tx_en = 1'b0;
    repeat (60) step();
    chk("en_drop_reads", rd_cnt, 4);
    chk("en_drop_frames", fd_cnt, 4);
    tx_en = 1'b1;
    repeat (100) step();
    chk("drain_reads", rd_cnt, 6);
    chk("drain_frames", fd_cnt, 6);

    // empty rising mid-frame
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    wait_rd("pre_empty_rd");
    force_empty = 1'b1;
    upd_empty();
    repeat (20) step();
    force_empty = 1'b0;
    upd_empty();
    repeat (110) step();
    chk("empty_mid_reads", rd_cnt, 8);
    chk("empty_mid_frames", fd_cnt, 8);

    // single byte, FIFO runs dry
    push_byte(8'($urandom));
    repeat (60) step();
    chk("single_reads", rd_cnt, 9);
    chk("single_busy_low", busy, 1'b0);

    // asynchronous reset during DATA bit 3
    push_byte(8'($urandom));
    push_byte(8'($urandom));
    wait_rd("pre_reset_rd");
    repeat (20) step();
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_rd", fifo_rd, 1'b0);
    exp_q.delete();
    repeat (2) step();
    rst = 1'b1;
    repeat (50) step();
    chk("post_reset_reads", rd_cnt, 11);
    chk("post_reset_frames", fd_cnt, 10);

    // randomised traffic
    for (int r = 0; r < 6; r++) begin
      int n;
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) push_byte(8'($urandom));
      tx_en = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(20, 120)) step();
    end
    tx_en = 1'b1;
    repeat (200) step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
